controle_jogo: RTL and testbench

Parametrised game controller, successor to the fixed-size control FSM of the sequence-memory game. Drives the datapath command lines (`r1`, `r2`, `e1`–`e4`, `sel`) from `end_fpga`, `end_user`, `match` and the user `enter` switch. Adds four things: configurable round count, multiple lives with round retry, an internal per-entry timeout selected by a difficulty input, and explicit win/lose outputs. It sits between the switches and `Datapath` in the top level.

---
 rtl/jogo_pkg.sv | 32 +++
 rtl/controle_jogo_if.sv | 23 ++
 rtl/controle_jogo_tick_timer.sv | 52 +++++
 rtl/controle_jogo.sv | 180 ++++++++++++++++++
 tb/tb_controle_jogo.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game controller: state codes,
// state width and the per-entry time limit helper.
package jogo_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_SETUP = 3'd1;
    localparam logic [STATE_W-1:0] ST_SEQ   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PLAY  = 3'd3;
    localparam logic [STATE_W-1:0] ST_CHECK = 3'd4;
    localparam logic [STATE_W-1:0] ST_WIN   = 3'd5;
    localparam logic [STATE_W-1:0] ST_LOSE  = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_SETUP = ST_SETUP,
        S_SEQ   = ST_SEQ,
        S_PLAY  = ST_PLAY,
        S_CHECK = ST_CHECK,
        S_WIN   = ST_WIN,
        S_LOSE  = ST_LOSE
    } state_t;

    // Harder settings halve the allowance; never drop below one second.
    function automatic int limit_secs(input int base, input logic [1:0] diff);
        int l;
        l = base >> diff;
        return (l < 1) ? 1 : l;
    endfunction

endpackage

// File: rtl/controle_jogo_if.sv
// Command/status lines between the game controller and the datapath.
interface controle_jogo_if;
    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;
    logic end_fpga;
    logic end_user;
    logic match;

    modport master (
        output r1, r2, e1, e2, e3, e4, sel,
        input  end_fpga, end_user, match
    );

    modport slave (
        input  r1, r2, e1, e2, e3, e4, sel,
        output end_fpga, end_user, match
    );
endinterface

// File: rtl/controle_jogo_tick_timer.sv
// Entry timeout: a prescaler producing one-second steps plus a seconds counter;
// expired is raised in the last cycle of the allowed window.
module tick_timer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_S         = 8
) (
    input  logic                         clock_50,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         enable,
    input  logic [$clog2(MAX_S+1)-1:0]   limit,
    output logic                         expired
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SW = $clog2(MAX_S + 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] sec_q, sec_d;
    logic          sec_end;

    always_comb begin
        sec_end = (presc_q == PW'(TICKS_PER_SEC - 1));
        // A clear in the same cycle counts as fresh activity and defers the timeout.
        expired = enable && !clear && sec_end && (sec_q == limit - SW'(1));
        presc_d = presc_q;
        sec_d   = sec_q;
        if (clear) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (enable) begin
            if (sec_end) begin
                presc_d = '0;
                if (sec_q != SW'(MAX_S)) begin
                    sec_d = sec_q + SW'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            presc_q <= '0;
            sec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end

endmodule

// File: rtl/controle_jogo.sv
// Game controller: sequences display, user entry and checking over a
// configurable number of rounds, with lives, retries and a per-entry timeout.
module controle_jogo
    import jogo_pkg::*;
#(
    parameter int ROUNDS        = 16,
    parameter int LIVES         = 3,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TIME_LIMIT_S  = 8,
    localparam int RW = $clog2(ROUNDS),
    localparam int LW = $clog2(LIVES + 1)
) (
    input  logic                 clock_50,
    input  logic                 reset,
    input  logic                 enter,
    input  logic [1:0]           difficulty,
    controle_jogo_if.master      dp,
    output logic [RW-1:0]        round,
    output logic [LW-1:0]        lives,
    output logic                 end_time,
    output logic                 win,
    output logic                 lose,
    output logic [STATE_W-1:0]   state
);
    localparam int SW = $clog2(TIME_LIMIT_S + 1);

    state_t        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [SW-1:0] limit_q, limit_d;
    logic          end_time_q, end_time_d;
    logic          enter_prev_q;

    logic enter_rise;
    logic fail;
    logic timer_clear;
    logic timer_en;
    logic expired;
    logic cmd_r1, cmd_r2, cmd_e1, cmd_e2, cmd_e3, cmd_e4, cmd_sel;

    assign enter_rise = enter && !enter_prev_q;
    assign fail       = end_time_q || !dp.match;
    assign timer_en   = (state_q == S_PLAY);

    tick_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .MAX_S         (TIME_LIMIT_S)
    ) u_timer (
        .clock_50 (clock_50),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (timer_en),
        .limit    (limit_q),
        .expired  (expired)
    );

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        lives_d     = lives_q;
        limit_d     = limit_q;
        end_time_d  = 1'b0;
        timer_clear = 1'b0;
        cmd_r1      = 1'b0;
        cmd_r2      = 1'b0;
        cmd_e1      = 1'b0;
        cmd_e2      = 1'b0;
        cmd_e3      = 1'b0;
        cmd_e4      = 1'b0;
        cmd_sel     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_r1  = 1'b1;
                cmd_r2  = 1'b1;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                cmd_e1 = 1'b1;
                if (enter_rise) begin
                    state_d = S_SEQ;
                    round_d = '0;
                    lives_d = LW'(LIVES);
                    limit_d = SW'(limit_secs(TIME_LIMIT_S, difficulty));
                end
            end
            S_SEQ: begin
                cmd_e2 = 1'b1;
                if (dp.end_fpga) begin
                    state_d     = S_PLAY;
                    timer_clear = 1'b1;
                end
            end
            S_PLAY: begin
                cmd_sel     = 1'b1;
                cmd_e3      = enter_rise;
                timer_clear = enter_rise;
                // A completed entry beats a timeout landing in the same cycle.
                if (dp.end_user) begin
                    state_d = S_CHECK;
                end else if (expired) begin
                    state_d    = S_CHECK;
                    end_time_d = 1'b1;
                end
            end
            S_CHECK: begin
                cmd_r1 = 1'b1;
                if (fail) begin
                    if (lives_q == LW'(1)) begin
                        state_d    = S_LOSE;
                        lives_d    = '0;
                        end_time_d = end_time_q;
                    end else begin
                        state_d = S_SEQ;
                        lives_d = lives_q - LW'(1);
                    end
                end else if (round_q == RW'(ROUNDS - 1)) begin
                    state_d = S_WIN;
                end else begin
                    state_d = S_SEQ;
                    round_d = round_q + RW'(1);
                end
            end
            S_WIN: begin
                cmd_e4  = 1'b1;
                cmd_sel = 1'b1;
                if (enter_rise) begin
                    state_d = S_IDLE;
                end
            end
            S_LOSE: begin
                cmd_e4     = 1'b1;
                cmd_sel    = 1'b1;
                end_time_d = end_time_q;
                if (enter_rise) begin
                    state_d    = S_IDLE;
                    end_time_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q      <= S_IDLE;
            round_q      <= '0;
            lives_q      <= LW'(LIVES);
            limit_q      <= SW'(limit_secs(TIME_LIMIT_S, 2'd0));
            end_time_q   <= 1'b0;
            // Seed with the live level so a switch already up does not fire.
            enter_prev_q <= enter;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            lives_q      <= lives_d;
            limit_q      <= limit_d;
            end_time_q   <= end_time_d;
            enter_prev_q <= enter;
        end
    end

    assign dp.r1  = cmd_r1;
    assign dp.r2  = cmd_r2;
    assign dp.e1  = cmd_e1;
    assign dp.e2  = cmd_e2;
    assign dp.e3  = cmd_e3;
    assign dp.e4  = cmd_e4;
    assign dp.sel = cmd_sel;

    assign round    = round_q;
    assign lives    = lives_q;
    assign end_time = end_time_q;
    assign win      = (state_q == S_WIN);
    assign lose     = (state_q == S_LOSE);
    assign state    = state_q;

endmodule

// File: tb/tb_controle_jogo.sv
// Scoreboard bench for controle_jogo: stimulus queues the expected state
// transitions, a negedge monitor checks each one as the DUT presents it.
module tb_controle_jogo;

    logic       clock_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       enter    = 1'b1;
    logic [1:0] difficulty = 2'd0;
    logic [1:0] round;
    logic [1:0] lives;
    logic       end_time;
    logic       win;
    logic       lose;
    logic [2:0] state;

    controle_jogo_if dp ();

    controle_jogo #(
        .ROUNDS        (3),
        .LIVES         (2),
        .TICKS_PER_SEC (4),
        .TIME_LIMIT_S  (3)
    ) dut (
        .clock_50   (clock_50),
        .reset      (reset),
        .enter      (enter),
        .difficulty (difficulty),
        .dp         (dp),
        .round      (round),
        .lives      (lives),
        .end_time   (end_time),
        .win        (win),
        .lose       (lose),
        .state      (state)
    );

    always #5 clock_50 = ~clock_50;

    // One expected transition: the new state's outputs, plus how long the
    // previous state lasted and how many e3 strobes it produced (-1 = any).
    typedef struct {
        int st;
        int rnd;
        int lv;
        bit et;
        int dwell;
        int e3n;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Command lines {r1,r2,e1,e2,e4,sel} expected in each state.
    function automatic logic [5:0] cmd_of(input int st);
        case (st)
            0:       return 6'b110000;
            1:       return 6'b001000;
            2:       return 6'b000100;
            3:       return 6'b000001;
            4:       return 6'b100000;
            5, 6:    return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic push(input int st, input int rnd, input int lv, input bit et,
                        input int dwell, input int e3n);
        exp_t e;
        e.st = st; e.rnd = rnd; e.lv = lv; e.et = et; e.dwell = dwell; e.e3n = e3n;
        exp_q.push_back(e);
    endtask

    // Monitor: a transaction is any change of the state output after reset.
    initial begin
        int   last_st;
        int   cyc;
        int   e3cnt;
        int   txn;
        exp_t e;
        bit   ok;
        logic [5:0] cmd_act;
        last_st = -1; cyc = 0; e3cnt = 0; txn = 0;
        forever begin
            @(negedge clock_50);
            if (reset) begin
                last_st = -1; cyc = 0; e3cnt = 0;
            end else if (int'(state) != last_st) begin
                cmd_act = {dp.r1, dp.r2, dp.e1, dp.e2, dp.e4, dp.sel};
                total++;
                txn++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_txn %0d: state=%0d with nothing expected", txn, state);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (int'(state) == e.st) && (int'(round) == e.rnd) &&
                         (int'(lives) == e.lv) && (end_time === e.et) &&
                         (win === (e.st == 5)) && (lose === (e.st == 6)) &&
                         (cmd_act === cmd_of(e.st)) &&
                         (e.dwell < 0 || cyc == e.dwell) &&
                         (e.e3n < 0 || e3cnt == e.e3n);
                    if (ok)
                        $display("txn %0d ok: state=%0d round=%0d lives=%0d end_time=%0d prev_dwell=%0d",
                                 txn, state, round, lives, end_time, cyc);
                    else begin
                        bad++;
                        $display("FAIL txn_%0d: got state=%0d round=%0d lives=%0d end_time=%0d win=%0d lose=%0d cmd=%b dwell=%0d e3=%0d; want state=%0d round=%0d lives=%0d end_time=%0d cmd=%b dwell=%0d e3=%0d",
                                 txn, state, round, lives, end_time, win, lose, cmd_act, cyc, e3cnt,
                                 e.st, e.rnd, e.lv, e.et, cmd_of(e.st), e.dwell, e.e3n);
                    end
                end
                last_st = int'(state);
                cyc     = 1;
                e3cnt   = int'(dp.e3);
            end else begin
                cyc++;
                e3cnt += int'(dp.e3);
            end
        end
    end

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(state) != st && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (int'(state) != st) begin
            bad++;
            $display("FAIL wait_%s: state=%0d want %0d after %0d cycles", tag, state, st, n);
        end
    endtask

    task automatic enter_rise();
        enter = 1'b0;
        tick();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    // Stray end_user in SEQ must be ignored before the real end_fpga.
    task automatic fpga_done();
        dp.end_user = 1'b1;
        tick();
        dp.end_user = 1'b0;
        tick();
        dp.end_fpga = 1'b1;
        tick();
        dp.end_fpga = 1'b0;
    endtask

    // Stray end_fpga in PLAY must be ignored; match is held through CHECK.
    task automatic user_done(input bit m);
        dp.end_fpga = 1'b1;
        tick();
        dp.end_fpga = 1'b0;
        dp.match    = m;
        dp.end_user = 1'b1;
        tick();
        dp.end_user = 1'b0;
    endtask

    initial begin
        int n;
        dp.end_fpga = 1'b0;
        dp.end_user = 1'b0;
        dp.match    = 1'b0;

        // Reset with enter held high: one IDLE cycle, SETUP until a fresh rise.
        push(0, 0, 2, 0, -1, -1);
        push(1, 0, 2, 0, 1, 0);
        push(2, 0, 2, 0, 6, 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        enter_rise();

        // Three passing rounds to WIN.
        for (int r = 0; r < 3; r++) begin
            push(3, r, 2, 0, -1, 0);
            fpga_done();
            push(4, r, 2, 0, -1, 0);
            if (r < 2) push(2, r + 1, 2, 0, 1, 0);
            else       push(5, 2, 2, 0, 1, 0);
            user_done(1'b1);
            wait_state((r < 2) ? 2 : 5, 20, "round");
        end

        // WIN -> IDLE -> SETUP -> new game.
        push(0, 2, 2, 0, -1, 0);
        push(1, 2, 2, 0, 1, 0);
        enter_rise();
        wait_state(1, 10, "setup_after_win");
        push(2, 0, 2, 0, -1, 0);
        enter_rise();

        // Pass round 0, then fail round 1 twice: retry then LOSE.
        push(3, 0, 2, 0, -1, 0); fpga_done();
        push(4, 0, 2, 0, -1, 0); push(2, 1, 2, 0, 1, 0); user_done(1'b1);
        push(3, 1, 2, 0, -1, 0); fpga_done();
        push(4, 1, 2, 0, -1, 0); push(2, 1, 1, 0, 1, 0); user_done(1'b0);
        push(3, 1, 1, 0, -1, 0); fpga_done();
        push(4, 1, 1, 0, -1, 0); push(6, 1, 0, 0, 1, 0); user_done(1'b0);
        wait_state(6, 20, "lose_mismatch");

        push(0, 1, 0, 0, -1, 0);
        push(1, 1, 0, 0, 1, 0);
        enter_rise();
        wait_state(1, 10, "setup_after_lose");
        push(2, 0, 2, 0, -1, 0);
        enter_rise();

        // No enter in PLAY: timeout after 12 cycles, retry.
        push(3, 0, 2, 0, -1, 0); fpga_done();
        push(4, 0, 2, 1, 12, 0); push(2, 0, 1, 0, 1, 0);
        wait_state(4, 30, "timeout12");
        wait_state(2, 5, "retry_after_timeout");

        // Enter rise at PLAY cycle 10 restarts the window; timeout in cycle 22 -> LOSE.
        push(3, 0, 1, 0, -1, 0); fpga_done();
        push(4, 0, 1, 1, 23, 1); push(6, 0, 0, 1, 1, 0);
        repeat (10) tick();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        wait_state(6, 40, "lose_timeout");

        push(0, 0, 0, 0, -1, 0);
        push(1, 0, 0, 0, 1, 0);
        enter_rise();
        wait_state(1, 10, "setup_after_timeout_lose");
        push(2, 0, 2, 0, -1, 0);
        enter_rise();

        // end_user in the expiry cycle: pass with end_time low.
        push(3, 0, 2, 0, -1, 0); fpga_done();
        push(4, 0, 2, 0, 12, 0); push(2, 1, 2, 0, 1, 0);
        repeat (11) tick();
        dp.match    = 1'b1;
        dp.end_user = 1'b1;
        tick();
        dp.end_user = 1'b0;
        wait_state(2, 10, "simultaneous");

        // Reset in PLAY returns to IDLE with round and lives reinitialised.
        push(3, 1, 2, 0, -1, 0); fpga_done();
        repeat (3) tick();
        push(0, 0, 2, 0, -1, -1);
        push(1, 0, 2, 0, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        difficulty = 2'd2;
        wait_state(1, 10, "setup_after_reset");
        push(2, 0, 2, 0, -1, 0);
        enter_rise();

        // Difficulty 2: one-second limit, timeout after 4 cycles.
        push(3, 0, 2, 0, -1, 0); fpga_done();
        push(4, 0, 2, 1, 4, 0); push(2, 0, 1, 0, 1, 0);
        wait_state(2, 20, "timeout4");

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected transitions never seen, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
